// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES round controller.
//   - Round counts for the three AES key sizes.
//   - Encoding of the round-kind field driven to the shared round datapath.
//   - Controller FSM state encoding.
//   - Mode encodings (encrypt / decrypt).
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Round kind presented to the datapath alongside rnd_idx.
    typedef enum logic [1:0] {
        RK_INIT  = 2'b00,   // AddRoundKey only
        RK_FULL  = 2'b01,   // full round
        RK_FINAL = 2'b10    // last round, no (Inv)MixColumns
    } rnd_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_OUT   = 3'd4
    } ctrl_state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/aes_round_counter.sv
// Round counter for the AES round controller.
// Holds the round number r (0..NR), flags the last full round and turns r
// into a round-key index that walks upward for encryption and downward for
// decryption.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - restart at r=0 (block accepted)
//   advance    - step r by one (saturates at NR)
//   mode       - latched mode, selects index direction
//   idx_en     - when low, idx is forced to 0 (controller idle / output)
//   last       - r == NR-1, i.e. the current full round is the last one
//   idx        - round-key index for the datapath
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    input  logic       mode,
    input  logic       idx_en,
    output logic       last,
    output logic [3:0] idx
);

    localparam logic [3:0] NR_W = 4'(NR);

    logic [3:0] r_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= 4'd0;
        end else if (clear) begin
            r_reg <= 4'd0;
        end else if (advance && (r_reg != NR_W)) begin
            r_reg <= r_reg + 4'd1;
        end
    end

    assign last = (r_reg == (NR_W - 4'd1));

    // Decryption consumes the expanded key from the top down.
    always_comb begin
        idx = 4'd0;
        if (idx_en) begin
            idx = (mode == MODE_DEC) ? (NR_W - r_reg) : r_reg;
        end
    end

endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES block sequencer. Accepts one block over in_valid/in_ready,
// steps a single shared combinational round datapath through the initial
// AddRoundKey, NR-1 full rounds and the final round, then offers the result
// over out_valid/out_ready.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - input handshake; in_mode (0 enc, 1 dec), in_block
//   rnd_state            - current state register to the round datapath
//   rnd_idx              - round-key index
//   rnd_kind             - 00 initial ARK, 01 full round, 10 final round
//   rnd_inv              - latched mode, selects inverse transforms
//   rnd_result           - combinational datapath result for current rnd_*
//   out_valid/out_ready  - output handshake; out_block holds the result
//   busy                 - a block is in flight
module aes_round_controller
    import aes_pkg::*;
#(
    parameter int NR      = NR_128,   // 10, 12 or 14
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [BLOCK_W-1:0] in_block,
    output logic [BLOCK_W-1:0] rnd_state,
    output logic [3:0]         rnd_idx,
    output logic [1:0]         rnd_kind,
    output logic               rnd_inv,
    input  logic [BLOCK_W-1:0] rnd_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               busy
);

    ctrl_state_t        state_reg, state_next;
    logic [BLOCK_W-1:0] block_reg, block_next;
    logic               mode_reg, mode_next;
    // Holds in_ready low while reset is asserted and until the first
    // clock edge after release.
    logic               ready_en_reg;

    rnd_kind_t          kind;
    logic               accept;
    logic               cnt_advance;
    logic               cnt_idx_en;
    logic               cnt_last;

    assign in_ready  = ready_en_reg && (state_reg == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_reg != ST_IDLE);
    assign out_valid = (state_reg == ST_OUT);
    assign out_block = out_valid ? block_reg : '0;
    assign rnd_state = block_reg;
    assign rnd_inv   = mode_reg;
    assign rnd_kind  = kind;

    aes_round_counter #(
        .NR(NR)
    ) u_round_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .advance (cnt_advance),
        .mode    (mode_reg),
        .idx_en  (cnt_idx_en),
        .last    (cnt_last),
        .idx     (rnd_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            block_reg    <= '0;
            mode_reg     <= MODE_ENC;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            block_reg    <= block_next;
            mode_reg     <= mode_next;
            ready_en_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        block_next  = block_reg;
        mode_next   = mode_reg;
        kind        = RK_INIT;
        cnt_advance = 1'b0;
        cnt_idx_en  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    block_next = in_block;
                    mode_next  = in_mode;
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                kind        = RK_INIT;
                cnt_idx_en  = 1'b1;
                cnt_advance = 1'b1;
                block_next  = rnd_result;
                state_next  = ST_ROUND;
            end
            ST_ROUND: begin
                kind        = RK_FULL;
                cnt_idx_en  = 1'b1;
                cnt_advance = 1'b1;
                block_next  = rnd_result;
                if (cnt_last) begin
                    state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                kind       = RK_FINAL;
                cnt_idx_en = 1'b1;
                block_next = rnd_result;
                state_next = ST_OUT;
            end
            ST_OUT: begin
                // A new in_valid here is not seen until the IDLE cycle.
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_controller.sv
module tb_aes_round_controller;

    localparam int NR10 = 10;
    localparam int NR14 = 14;
    localparam int BW   = 128;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk;
    logic rst_n;

    logic          in_valid, in_ready, in_mode;
    logic [BW-1:0] in_block, rnd_state, rnd_result, out_block;
    logic [3:0]    rnd_idx;
    logic [1:0]    rnd_kind;
    logic          rnd_inv, out_valid, out_ready, busy;

    logic          in_valid14, in_ready14, in_mode14;
    logic [BW-1:0] in_block14, rnd_state14, rnd_result14, out_block14;
    logic [3:0]    rnd_idx14;
    logic [1:0]    rnd_kind14;
    logic          rnd_inv14, out_valid14, out_ready14, busy14;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk10  [15];
    logic [127:0] rk14  [15];

    logic [127:0] sb_q [$];
    int total;
    int bad;

    typedef struct {
        logic         mode;
        logic [127:0] blk;
        logic [127:0] exp;
        int           hold;
        bit           intrude;
        bit           overlap;
    } vec_t;
    vec_t tbl [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_round_controller #(.NR(NR10), .BLOCK_W(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_block(in_block),
        .rnd_state(rnd_state), .rnd_idx(rnd_idx), .rnd_kind(rnd_kind), .rnd_inv(rnd_inv),
        .rnd_result(rnd_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
    );

    aes_round_controller #(.NR(NR14), .BLOCK_W(BW)) dut14 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid14), .in_ready(in_ready14), .in_mode(in_mode14), .in_block(in_block14),
        .rnd_state(rnd_state14), .rnd_idx(rnd_idx14), .rnd_kind(rnd_kind14), .rnd_inv(rnd_inv14),
        .rnd_result(rnd_result14),
        .out_valid(out_valid14), .out_ready(out_ready14), .out_block(out_block14), .busy(busy14)
    );

    // ---------------- AES reference round model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
        logic [7:0]   co [4];
        logic [7:0]   a  [4];
        logic [7:0]   v;
        logic [127:0] o;
        co[0] = inv ? 8'h0e : 8'h02;
        co[1] = inv ? 8'h0b : 8'h03;
        co[2] = inv ? 8'h0d : 8'h01;
        co[3] = inv ? 8'h09 : 8'h01;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                v = 8'h00;
                for (int j = 0; j < 4; j++) v = v ^ gm(co[(j-r+4)%4], a[j]);
                o[127-8*(4*c+r) -: 8] = v;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [1:0] kind,
                                               input logic inv, input logic [127:0] key);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] res;
        if (kind == 2'b00) return st ^ key;
        for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = inv ? isbox[a[r+4*((c-r+4)%4)]] : sbox[a[r+4*((c+r)%4)]];
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
        if (!inv) begin
            if (kind == 2'b01) res = mix(res, 1'b0);
            res = res ^ key;
        end else begin
            res = res ^ key;
            if (kind == 2'b01) res = mix(res, 1'b1);
        end
        return res;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    function automatic logic [127:0] ref_cipher(input logic [127:0] b, input logic m, input int nr);
        logic [127:0] s;
        logic [1:0]   kd;
        int           ki;
        s = b;
        for (int k = 0; k <= nr; k++) begin
            kd = (k == 0) ? 2'b00 : ((k == nr) ? 2'b10 : 2'b01);
            ki = m ? nr - k : k;
            s  = aes_round(s, kd, m, (nr == NR14) ? rk14[ki] : rk10[ki]);
        end
        return s;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr, input bit big);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subword(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int k = 0; k <= nr; k++) begin
            if (big) rk14[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
            else     rk10[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        end
    endtask

    // Shared round datapath model for each controller.
    assign rnd_result   = aes_round(rnd_state,   rnd_kind,   rnd_inv,   rk10[rnd_idx]);
    assign rnd_result14 = aes_round(rnd_state14, rnd_kind14, rnd_inv14, rk14[rnd_idx14]);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 128'(act), 128'(exp));
    endtask

    task automatic run_block(input int id, input logic mode, input logic [127:0] blk,
                             input logic [127:0] exp, input int hold,
                             input bit intrude, input bit overlap);
        int           waited;
        int           lat;
        logic [3:0]   exp_idx;
        logic [1:0]   exp_kind;
        logic [127:0] want;
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk1("accept_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_block  = blk;
        out_ready = 1'b0;
        @(posedge clk);
        sb_q.push_back(exp);
        @(negedge clk);
        in_mode  = ~mode;
        in_block = ~blk;
        for (int k = 0; k <= NR10; k++) begin
            in_valid = 1'b0;
            exp_kind = (k == 0) ? 2'b00 : ((k == NR10) ? 2'b10 : 2'b01);
            exp_idx  = mode ? 4'(NR10 - k) : 4'(k);
            if (k == 0) chk("rnd_state_init", rnd_state, blk);
            chk("rnd_kind", 128'(rnd_kind), 128'(exp_kind));
            chk("rnd_idx", 128'(rnd_idx), 128'(exp_idx));
            chk1("rnd_inv", rnd_inv, mode);
            chk1("busy_run", busy, 1'b1);
            chk1("in_ready_run", in_ready, 1'b0);
            chk1("out_valid_early", out_valid, 1'b0);
            if (intrude && k == 5) in_valid = 1'b1;   // must be ignored
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = NR10 + 1;
        while (!out_valid && lat < NR10 + 30) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 128'(lat), 128'(NR10 + 1));
        want = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        chk("out_block", out_block, want);
        chk("rnd_idx_out", 128'(rnd_idx), 128'(0));
        chk("rnd_kind_out", 128'(rnd_kind), 128'(0));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk1("hold_valid", out_valid, 1'b1);
            chk("hold_block", out_block, want);
            chk1("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        if (overlap) begin
            in_valid = 1'b1;
            in_mode  = 1'b0;
            in_block = '0;
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk1("idle_out_valid", out_valid, 1'b0);
        chk1("idle_in_ready", in_ready, 1'b1);
        chk1("idle_busy", busy, 1'b0);
        $display("txn %0d mode=%0d in=%h out=%h lat=%0d hold=%0d", id, mode, blk, want, lat, hold);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int           waited;
        int           lat;
        logic         ov_seen;
        logic [127:0] r0;
        logic [127:0] r1;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_mode = 1'b0; in_block = '0; out_ready = 1'b0;
        in_valid14 = 1'b0; in_mode14 = 1'b0; in_block14 = '0; out_ready14 = 1'b0;

        build_sbox();
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR10, 1'b0);
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NR14, 1'b1);

        r0 = {$urandom, $urandom, $urandom, $urandom};
        r1 = {$urandom, $urandom, $urandom, $urandom};
        tbl[0] = '{1'b0, PT,   CT10, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, CT10, PT,   5, 1'b0, 1'b1};
        tbl[2] = '{1'b0, PT,   CT10, 0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, r0, ref_cipher(r0, 1'b0, NR10), 1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, r1, ref_cipher(r1, 1'b1, NR10), 2, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_out_block", out_block, '0);
        chk("rst_rnd_state", rnd_state, '0);
        chk("rst_rnd_idx", 128'(rnd_idx), 128'(0));
        chk("rst_rnd_kind", 128'(rnd_kind), 128'(0));
        chk1("rst_rnd_inv", rnd_inv, 1'b0);
        chk1("rst_in_ready14", in_ready14, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        chk1("post_rst_in_ready14", in_ready14, 1'b1);

        for (int i = 0; i < 5; i++)
            run_block(i, tbl[i].mode, tbl[i].blk, tbl[i].exp, tbl[i].hold,
                      tbl[i].intrude, tbl[i].overlap);

        // Reset in the middle of a decrypt: block is discarded.
        in_valid = 1'b1; in_mode = 1'b1; in_block = CT10;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (rnd_idx != 4'd5 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("reach_round5_kind", 128'(rnd_kind), 128'(2'b01));
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_block", out_block, '0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rnd_state", rnd_state, '0);
        chk("mid_rst_rnd_idx", 128'(rnd_idx), 128'(0));
        chk("mid_rst_rnd_kind", 128'(rnd_kind), 128'(0));
        chk1("mid_rst_rnd_inv", rnd_inv, 1'b0);
        chk1("mid_rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        chk1("mid_rst_in_ready_held", in_ready, 1'b0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk1("mid_rst_release_ready", in_ready, 1'b1);
        ov_seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            ov_seen = ov_seen | out_valid;
            @(negedge clk);
        end
        chk1("mid_rst_no_out_pulse", ov_seen, 1'b0);
        $display("txn reset-abort mode=1 in=%h discarded", CT10);
        run_block(5, 1'b0, PT, CT10, 0, 1'b0, 1'b0);

        // AES-256 build.
        chk1("nr14_ready", in_ready14, 1'b1);
        in_valid14 = 1'b1; in_mode14 = 1'b0; in_block14 = PT;
        @(posedge clk);
        sb_q.push_back(CT14);
        @(negedge clk);
        in_valid14 = 1'b0;
        lat = 0;
        while (!out_valid14 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("nr14_latency", 128'(lat), 128'(NR14 + 1));
        chk("nr14_out_block", out_block14, (sb_q.size() > 0) ? sb_q.pop_front() : '0);
        out_ready14 = 1'b1;
        @(negedge clk);
        out_ready14 = 1'b0;
        chk1("nr14_idle_ready", in_ready14, 1'b1);
        $display("txn nr14 mode=0 in=%h out=%h lat=%0d", PT, out_block14, lat);

        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_round_controller.md
Name: aes_round_controller

Overview:
Iterative sequencer that time-shares one combinational AES round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey and their inverses) across all rounds of one block.
- Accepts a 128-bit block plus mode over a valid/ready handshake.
- Owns the state register; drives round index, round kind and direction to the shared datapath; captures its result each cycle.
- Presents the finished block over a second valid/ready handshake.
- Replaces the free-running counter sequencing in the AES top level, between the input source and the key-expansion/round hardware.

Parameters:
- NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256).
- BLOCK_W, 128, block width in bits; fixed by AES, parameterised for bench readability only.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input block offered
- in_ready  out  1  controller can accept a block
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled at acceptance
- in_block  in  BLOCK_W  plaintext or ciphertext
- rnd_state  out  BLOCK_W  current state to round datapath
- rnd_idx  out  4  round-key index into expanded key words
- rnd_kind  out  2  00 initial AddRoundKey only, 01 full round, 10 final round (no (Inv)MixColumns), 11 unused
- rnd_inv  out  1  latched mode, selects inverse transforms
- rnd_result  in  BLOCK_W  combinational datapath result for current rnd_*
- out_valid  out  1  result block available
- out_ready  in  1  consumer takes result
- out_block  out  BLOCK_W  ciphertext or plaintext
- busy  out  1  block in flight (state not IDLE)

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, round counter r=0, state register=0, mode=0.
  - Outputs during reset: out_valid=0, out_block=0, busy=0, rnd_state=0, rnd_idx=0, rnd_kind=00, rnd_inv=0, in_ready=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
- FSM states: IDLE, INIT, ROUND, FINAL, OUT.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch in_block into the state register and in_mode into mode; r=0; go to INIT.
- INIT: rnd_kind=00. Capture rnd_result; r=1; go to ROUND.
- ROUND: rnd_kind=01. Capture rnd_result; r=r+1.
  - When r==NR-1 at the edge, go to FINAL.
- FINAL: rnd_kind=10. Capture rnd_result into the state register; go to OUT.
- OUT: out_valid=1 and out_block=state register.
  - Both are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- Round-key index: rnd_idx = r when mode=0; rnd_idx = NR-r when mode=1.
  - Encrypt sequence: 0,1..NR.
  - Decrypt sequence: NR,NR-1..0.
- rnd_inv = mode; constant for the whole block.
- rnd_state = state register in all states.
  - rnd_kind=00 and rnd_idx=0 in IDLE/OUT; the datapath output is ignored there.
- Latency: acceptance edge T → out_valid high after edge T+NR+1 (11 cycles for NR=10). Minimum issue interval NR+3 cycles.
- in_ready=0 in every state except IDLE. in_valid while busy is ignored; there is no queuing.
- busy=1 in INIT, ROUND, FINAL, OUT.
- Simultaneous out_ready and a new in_valid in OUT: the output is consumed; the new block is accepted only in the following IDLE cycle.
- Reset mid-operation: in-flight block is discarded; no out_valid pulse.
- Counter r is 4 bits; it never exceeds NR, and there is no wrap-around.

Decomposition:
- Package aes_pkg holds:
  - NR_128/NR_192/NR_256 constants;
  - rnd_kind encodings (RK_INIT, RK_FULL, RK_FINAL);
  - FSM state encoding;
  - MODE_ENC/MODE_DEC.
- Natural sub-module: aes_round_counter (r register, terminal-count flag, direction-aware rnd_idx).
- FSM and state register stay in the parent.

Test Plan:
- Encrypt, NR=10: in_block=00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f via bench round model → out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after acceptance, rnd_idx sequence 0..10.
- Decrypt, NR=10: in_block=69c4e0d86a7b0430d8cdb78070b4c55a, in_mode=1 → out_block=00112233445566778899aabbccddeeff, rnd_idx 10..0, rnd_inv=1 throughout, kinds 00,01×9,10.
- Back-pressure: out_ready low for 5 cycles after out_valid → out_block and out_valid stable, in_ready=0; raise out_ready → IDLE next cycle, in_ready=1.
- Busy rejection: pulse in_valid with a different block during ROUND → ignored; output still matches the first block.
- Reset mid-operation: assert rst_n=0 at round 5 → all outputs zero immediately; after release in_ready=1, out_valid never pulses; a new encrypt completes correctly.
- NR=14 build: encrypt FIPS-197 AES-256 vector (key 000102…1f) → 8ea2b7ca516745bfeafc49904b496089, latency 15 cycles.
